// File: rtl/ahb3lite_burst_master.sv
// AHB3-Lite burst master: turns one command into a SINGLE/INCR4/INCR8 burst.
// Ports: HCLK/HRESET (sync, active-high); cmd_* command handshake;
// wdata/wdata_valid/wdata_ready write stream; rdata/rdata_valid/done/err
// completion; H* AHB master bus. Optional err_count output when
// AHB_MASTER_ERR_CNT_EN is defined (saturating error counter).
module ahb3lite_burst_master #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [2:0]            cmd_burst,
  input  logic [HDATA_SIZE-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [HDATA_SIZE-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  err,
`ifdef AHB_MASTER_ERR_CNT_EN
  output logic [7:0]            err_count,
`endif
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_NSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ  = 2'b11;

  typedef enum logic [1:0] {IDLE, BURST, LAST} state_t;

  state_t state, state_n;

  logic [3:0] beats;
  logic [3:0] cmd_beats;
  logic [2:0] cmd_hburst;
  logic       first;
  logic       committed;
  logic       dp_valid;
  logic       abort;
  logic       go;
  logic       adv;
  logic       dp_err;

  logic [HADDR_SIZE-1:0] incr;

  assign HPROT = 4'b0011;
  assign incr  = {{(HADDR_SIZE-1){1'b0}}, 1'b1} << HSIZE;
  assign rdata = rdata_valid ? HRDATA : '0;

  always_comb begin
    cmd_beats  = 4'd1;
    cmd_hburst = 3'b000;
    unique case (cmd_burst)
      3'b011: begin
        cmd_beats  = 4'd4;
        cmd_hburst = 3'b011;
      end
      3'b101: begin
        cmd_beats  = 4'd8;
        cmd_hburst = 3'b101;
      end
      default: begin
        cmd_beats  = 4'd1;
        cmd_hburst = 3'b000;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cmd_ready   = 1'b0;
    go          = 1'b0;
    adv         = 1'b0;
    dp_err      = 1'b0;
    HSEL        = 1'b0;
    HTRANS      = TR_IDLE;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = !HRESET;
        if (cmd_valid && !HRESET) state_n = BURST;
      end
      BURST: begin
        // once a transfer is on the bus it stays there while stalled
        go          = !HWRITE || wdata_valid || committed;
        adv         = go && HREADY;
        dp_err      = dp_valid && !HREADY && HRESP;
        HSEL        = go || !first;
        HTRANS      = go ? (first ? TR_NSEQ : TR_SEQ)
                         : (first ? TR_IDLE : TR_BUSY);
        wdata_ready = HWRITE && adv;
        rdata_valid = dp_valid && !HWRITE && HREADY && !HRESP;
        if (dp_err)                    state_n = LAST;
        else if (adv && beats == 4'd1) state_n = LAST;
      end
      LAST: begin
        HSEL = 1'b1;
        if (abort) begin
          // second cycle of the two-cycle error response
          err     = 1'b1;
          state_n = IDLE;
        end else begin
          rdata_valid = !HWRITE && HREADY && !HRESP;
          done        = HREADY && !HRESP;
          dp_err      = !HREADY && HRESP;
          if (HREADY) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'b000;
      HBURST    <= 3'b000;
      HWDATA    <= '0;
      beats     <= 4'd0;
      first     <= 1'b0;
      committed <= 1'b0;
      dp_valid  <= 1'b0;
      abort     <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        HADDR     <= cmd_addr;
        HWRITE    <= cmd_write;
        HSIZE     <= cmd_size;
        HBURST    <= cmd_hburst;
        beats     <= cmd_beats;
        first     <= 1'b1;
        committed <= 1'b0;
        dp_valid  <= 1'b0;
        abort     <= 1'b0;
      end
      if (state == BURST) begin
        committed <= go && !HREADY;
        if (HREADY) begin
          dp_valid <= go;
          if (go) begin
            first <= 1'b0;
            if (beats != 4'd1) HADDR <= HADDR + incr;
            beats <= beats - 4'd1;
          end
        end
      end
      if (dp_err) abort <= 1'b1;
      if (state == LAST && abort) begin
        abort <= 1'b0;
        beats <= 4'd0;
      end
      if (wdata_ready) HWDATA <= wdata;
    end
  end

`ifdef AHB_MASTER_ERR_CNT_EN
  always_ff @(posedge HCLK) begin
    if (HRESET)                        err_count <= 8'd0;
    else if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: doc/ahb3lite_burst_master.md
AHB3LITE_BURST_MASTER -- requirements
Module: ahb3lite_burst_master

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, data width.
REQ-003 SHALL have port HCLK  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port HRESET  in  1  reset, synchronous and active-high.
REQ-005 SHALL have command ports:
- cmd_valid  in  1
- cmd_ready  out  1
- cmd_addr  in  HADDR_SIZE
- cmd_write  in  1
- cmd_size  in  3
- cmd_burst  in  3
REQ-006 SHALL have write-data ports: wdata  in  HDATA_SIZE; wdata_valid  in  1; wdata_ready  out  1.
REQ-007 SHALL have completion ports:
- rdata  out  HDATA_SIZE
- rdata_valid  out  1
- done  out  1  successful-command pulse
- err  out  1  error-abort pulse
REQ-008 SHALL have AHB master outputs:
- HSEL  1
- HADDR  HADDR_SIZE
- HWRITE  1
- HSIZE  3
- HBURST  3
- HPROT  4
- HTRANS  2
- HWDATA  HDATA_SIZE
REQ-009 SHALL have AHB inputs: HRDATA  HDATA_SIZE; HREADY  1; HRESP  1.

Function
REQ-010 SHALL implement states IDLE, BURST (address phases outstanding) and LAST (final data phase only).
REQ-011 SHALL assert cmd_ready only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-012 SHALL map beat count from cmd_burst as follows:
- 000 SINGLE: 1 beat
- 011 INCR4: 4 beats
- 101 INCR8: 8 beats
- any other code: 1 beat, with HBURST driven as 000
REQ-013 SHALL drive the first address phase (HTRANS=NONSEQ, HADDR=cmd_addr) in the cycle after acceptance; subsequent beats SHALL drive SEQ with HADDR incremented by (1<<HSIZE), modulo 2^HADDR_SIZE.
REQ-014 SHALL advance the address phase only on cycles with HREADY=1; while HREADY=0, all address-phase outputs SHALL hold stable.
REQ-015 SHALL pipeline the data phase of beat n with the address phase of beat n+1.
REQ-016 SHALL, for write beats, issue NONSEQ/SEQ only while wdata_valid=1:
- if wdata_valid=0 mid-burst, drive HTRANS=BUSY with HADDR already advanced;
- if wdata_valid=0 on the first beat, drive IDLE with HSEL=0.
REQ-017 SHALL assert wdata_ready exactly in cycles where a write NONSEQ/SEQ is driven and HREADY=1; that word SHALL appear on HWDATA from the next cycle and hold until its data phase completes.
REQ-018 SHALL, for read beats, pulse rdata_valid with rdata=HRDATA on each data-phase cycle with HREADY=1 and HRESP=0.
REQ-019 SHALL drive HPROT=0011 constant.
REQ-020 SHALL drive HSEL=1 from the first NONSEQ through the final data phase.
REQ-021 SHALL, on a data-phase cycle with HREADY=0 and HRESP=1, do all of the following:
- drive HTRANS=IDLE next cycle;
- cancel remaining beats;
- pulse err once on the second error cycle;
- return to IDLE with no done pulse.
REQ-022 SHALL pulse done for one cycle when the last beat's data phase completes with HREADY=1 and HRESP=0; cmd_ready SHALL be high the following cycle.
REQ-023 SHALL not check alignment or 1 KB boundaries; legal commands are a caller precondition.

Reset
REQ-024 SHALL, on any HCLK edge with HRESET=1, enter IDLE, clear the beat counter and enter the following output values:

| Output | Value |
|---|---|
| HTRANS | 00 |
| HSEL | 0 |
| HADDR | 0 |
| HWRITE | 0 |
| HSIZE | 0 |
| HBURST | 0 |
| HWDATA | 0 |
| rdata | 0 |
| rdata_valid | 0 |
| done | 0 |
| err | 0 |
| wdata_ready | 0 |

REQ-025 SHALL, on reset mid-burst, abandon the burst without a done or err pulse; cmd_ready SHALL be 0 while HRESET=1.

Configuration
REQ-026 SHALL compile in the output err_count (8 bits) when AHB_MASTER_ERR_CNT_EN is defined:
- increments on each err pulse;
- saturates at 255;
- resets to 0.
REQ-027 SHALL omit the err_count port and its logic when AHB_MASTER_ERR_CNT_EN is undefined; all other behaviour is identical.

Verification
REQ-028 SINGLE write 0x0000 data 0xCAFEBABE size 010, HREADY=1 -> NONSEQ at cycle+1, HWDATA=0xCAFEBABE at cycle+2, done at cycle+2.
REQ-029 SINGLE read 0x0004, slave inserts 2 wait states -> HADDR/HTRANS held, rdata_valid with rdata=0xDEADBEEF after wait states, then done.
REQ-030 INCR4 write base 0x0000 with words 0x11111111..0x44444444 -> HADDR 0,4,8,C; HTRANS NONSEQ,SEQ,SEQ,SEQ; single done pulse.
REQ-031 INCR4 write, wdata_valid dropped 2 cycles before beat 3 -> HTRANS=BUSY for 2 cycles at HADDR 0x8, then SEQ resumes.
REQ-032 INCR8 read, HRESP error on beat 2 -> HTRANS=IDLE next cycle, err pulse, no done; err_count=1 with AHB_MASTER_ERR_CNT_EN defined.
REQ-033 HRESET=1 asserted mid-INCR8 -> HTRANS=IDLE and HSEL=0 after the edge, no done or err, cmd_ready=1 on the first cycle after HRESET deasserts.
